// File: rtl/mmio_input_ctrl.sv
// rtl/mmio_input_ctrl.sv - NUM_CH synchronized, debounced inputs with W1C edge pending and maskable irq
// Optional hold/long-press detection is built only when INPUT_LONGPRESS_EN is defined.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h8000_0000
`endif
`ifndef IO_BTN_OFFSET
`define IO_BTN_OFFSET 32'h0000_0040
`endif

module mmio_input_ctrl #(
  parameter int unsigned         NUM_CH      = 5,
  parameter bit                  ACTIVE_LOW  = 1'b0,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         CNT_W       = 20,
  parameter logic [CNT_W-1:0]    DB_RESET    = CNT_W'(100000),
  parameter logic [`ADDR_W-1:0]  BASE_ADDR   = `IO_BASE_ADDR + `IO_BTN_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mmio_req,
  input  logic               mmio_we,
  input  logic [`ADDR_W-1:0] mmio_addr,
  input  logic [`XLEN-1:0]   mmio_wdata,
  output logic [`XLEN-1:0]   mmio_rdata,
  output logic               mmio_ready,
  input  logic [NUM_CH-1:0]  in_raw,
  output logic               irq
);
  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [NUM_CH-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]  state_q, rise_q, fall_q, en_rise_q, en_fall_q;
  logic [CNT_W-1:0]   db_cfg_q;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic               ready_q;
  logic [`XLEN-1:0]   rdata_q, rdata_d;
  logic [`ADDR_W-1:0] off;
  logic               in_blk, wr, wr_rise, wr_fall, wr_en, wr_db, irq_lp;
  logic [2:0]         widx;
  logic [NUM_CH-1:0]  sync_w, diff, fire, rise_set, fall_set;
  logic [CNT_W-1:0]   keff_m1;
  logic               unused_bits;

  assign off     = mmio_addr - BASE_ADDR;
  assign in_blk  = (off[`ADDR_W-1:5] == '0);
  assign widx    = off[4:2];
  assign wr      = mmio_req & mmio_we & in_blk;
  assign wr_rise = wr && (widx == 3'd2);
  assign wr_fall = wr && (widx == 3'd3);
  assign wr_en   = wr && (widx == 3'd4);
  assign wr_db   = wr && (widx == 3'd5);
  assign unused_bits = ^{off[1:0], mmio_wdata};

  assign sync_w  = sync_q[LAST];
  assign keff_m1 = (db_cfg_q == '0) ? '0 : db_cfg_q - CNT_W'(1);
  assign diff    = sync_w ^ state_q;

  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_CH; i++) fire[i] = diff[i] && (cnt_q[i] == keff_m1);
  end
  assign rise_set = fire & sync_w;
  assign fall_set = fire & ~sync_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ACTIVE_LOW ? ~in_raw : in_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Hardware sets are ORed after the W1C mask so a coincident edge survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      en_rise_q <= '0;
      en_fall_q <= '0;
      db_cfg_q  <= DB_RESET;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_q ^ fire;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= (wr_db || !diff[i] || fire[i]) ? '0 : cnt_q[i] + CNT_W'(1);
      rise_q <= (wr_rise ? (rise_q & ~mmio_wdata[NUM_CH-1:0]) : rise_q) | rise_set;
      fall_q <= (wr_fall ? (fall_q & ~mmio_wdata[NUM_CH-1:0]) : fall_q) | fall_set;
      if (wr_en) begin
        en_rise_q <= mmio_wdata[NUM_CH-1:0];
        en_fall_q <= mmio_wdata[16 +: NUM_CH];
      end
      if (wr_db) db_cfg_q <= mmio_wdata[CNT_W-1:0];
    end
  end

`ifdef INPUT_LONGPRESS_EN
  logic [23:0]       lp_l_q;
  logic              lp_ie_q, wr_lpc, wr_lpp;
  logic [NUM_CH-1:0] lp_pend_q, lp_hit;
  logic [23:0]       hold_q [NUM_CH];

  assign wr_lpc = wr && (widx == 3'd6);
  assign wr_lpp = wr && (widx == 3'd7);

  // Saturating hold counter reaches L at most once per press.
  always_comb begin
    lp_hit = '0;
    for (int i = 0; i < NUM_CH; i++)
      lp_hit[i] = state_q[i] && (lp_l_q != '0) && (hold_q[i] != '1) && (hold_q[i] + 24'd1 == lp_l_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_l_q    <= '0;
      lp_ie_q   <= 1'b0;
      lp_pend_q <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        hold_q[i] <= !state_q[i] ? '0 : ((hold_q[i] == '1) ? hold_q[i] : hold_q[i] + 24'd1);
      lp_pend_q <= (wr_lpp ? (lp_pend_q & ~mmio_wdata[NUM_CH-1:0]) : lp_pend_q) | lp_hit;
      if (wr_lpc) begin
        lp_l_q  <= mmio_wdata[23:0];
        lp_ie_q <= mmio_wdata[31];
      end
    end
  end
  assign irq_lp = (|lp_pend_q) & lp_ie_q;
`else
  assign irq_lp = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    if (in_blk) begin
      case (widx)
        3'd0: rdata_d[NUM_CH-1:0] = state_q;
        3'd1: rdata_d[NUM_CH-1:0] = sync_w;
        3'd2: rdata_d[NUM_CH-1:0] = rise_q;
        3'd3: rdata_d[NUM_CH-1:0] = fall_q;
        3'd4: begin
          rdata_d[NUM_CH-1:0]  = en_rise_q;
          rdata_d[16 +: NUM_CH] = en_fall_q;
        end
        3'd5: rdata_d[CNT_W-1:0] = db_cfg_q;
`ifdef INPUT_LONGPRESS_EN
        3'd6: begin
          rdata_d[23:0] = lp_l_q;
          rdata_d[31]   = lp_ie_q;
        end
        3'd7: rdata_d[NUM_CH-1:0] = lp_pend_q;
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= mmio_req;
      if (mmio_req) rdata_q <= rdata_d;
    end
  end

  assign mmio_ready = ready_q;
  assign mmio_rdata = rdata_q;
  assign irq = (|(rise_q & en_rise_q)) | (|(fall_q & en_fall_q)) | irq_lp;
endmodule
